// File: rtl/button_press_emulator.sv
// Emulated bouncy push-button: on request, produces N press/release cycles
// with pseudo-random chatter on each edge, plus the ideal level for scoreboarding.
module button_press_emulator #(
  parameter int          BOUNCE_TICKS = 150,
  parameter int          HOLD_TICKS   = 1000,
  parameter int          GAP_TICKS    = 1000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [3:0] req_count,
  output logic       req_ready,
  output logic       bouncy_out,
  output logic       clean_out,
  output logic       busy,
  output logic       done
);

  localparam int MAX_A     = (BOUNCE_TICKS > HOLD_TICKS) ? BOUNCE_TICKS : HOLD_TICKS;
  localparam int MAX_TICKS = (MAX_A > GAP_TICKS) ? MAX_A : GAP_TICKS;
  localparam int TIMER_W   = $clog2(MAX_TICKS) + 1;

  localparam logic [TIMER_W-1:0] BOUNCE_LAST = TIMER_W'(BOUNCE_TICKS - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_TICKS - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST    = TIMER_W'(GAP_TICKS - 1);
  localparam logic [15:0]        LFSR_MASK   = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESS   = 3'd1,
    S_HOLD    = 3'd2,
    S_RELEASE = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [3:0]           remaining_q, remaining_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic                 done_q, done_d;

  // Galois LFSR step; free-running so chatter differs between presses
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
  end

  // Register the FSM, timer, press counter, LFSR and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      remaining_q <= '0;
      lfsr_q      <= LFSR_SEED;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      lfsr_q      <= lfsr_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic and Moore outputs
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    req_ready   = 1'b0;
    busy        = 1'b0;
    bouncy_out  = 1'b0;
    clean_out   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        timer_d   = '0;
        if (req_valid) begin
          if (req_count == 4'd0) begin
            done_d = 1'b1;
          end else begin
            remaining_d = req_count;
            state_d     = S_PRESS;
          end
        end
      end
      S_PRESS: begin
        busy       = 1'b1;
        clean_out  = 1'b1;
        // last chatter cycle settles to the pressed level
        bouncy_out = (timer_q == BOUNCE_LAST) ? 1'b1 : lfsr_q[0];
        if (timer_q == BOUNCE_LAST) begin
          timer_d = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        busy       = 1'b1;
        clean_out  = 1'b1;
        bouncy_out = 1'b1;
        if (timer_q == HOLD_LAST) begin
          timer_d = '0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        busy       = 1'b1;
        // last chatter cycle settles to the released level
        bouncy_out = (timer_q == BOUNCE_LAST) ? 1'b0 : lfsr_q[0];
        if (timer_q == BOUNCE_LAST) begin
          timer_d = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        busy = 1'b1;
        if (timer_q == GAP_LAST) begin
          timer_d     = '0;
          remaining_d = remaining_q - 4'd1;
          if (remaining_q == 4'd1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_PRESS;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        timer_d     = '0;
        remaining_d = '0;
      end
    endcase
  end

  assign done = done_q;

endmodule
